// File: rtl/translator_pkg.sv
// Shared types for the pmesh translator stage and its TLB cache.
// Page numbers, cache entries and cache FSM states.
package translator_pkg;

  localparam int PN_W = 20;

  typedef logic [PN_W-1:0] pn_t;

  typedef struct packed {
    logic valid;
    pn_t  vpn;
    pn_t  ppn;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_FILL,
    S_RESP
  } tlb_cache_state_t;

endpackage

// File: rtl/tlb_if.sv
// Translation query handshake between the translator stage and its TLB.
// valid/vpn held until a one-cycle ack carrying ppn.
interface tlb_if;
  import translator_pkg::*;

  logic valid;
  pn_t  vpn;
  logic ack;
  pn_t  ppn;

  modport master (
    output valid,
    output vpn,
    input  ack,
    input  ppn
  );

  modport slave (
    input  valid,
    input  vpn,
    output ack,
    output ppn
  );

endinterface

// File: rtl/tlb_cache_array.sv
// Fully-associative entry storage for tlb_cache_unit.
// Parallel VPN match, install port, flush clear, first-invalid finder.
module tlb_cache_array
  import translator_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  pn_t              lookup_vpn,
  input  logic             flush,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  tlb_entry_t       wentry,
  output logic             hit,
  output logic [IDX_W-1:0] hit_idx,
  output pn_t              hit_ppn,
  output logic             multi_hit,
  output logic             any_inv,
  output logic [IDX_W-1:0] inv_idx
);

  tlb_entry_t           mem [ENTRIES];
  logic [ENTRIES-1:0]   match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i].valid <= 1'b0;
      end
    end else if (we) begin
      mem[widx] <= wentry;
    end
  end

  always_comb begin
    match   = '0;
    hit_idx = '0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = mem[i].valid &&
                 (mem[i].vpn == lookup_vpn);
      if (match[i]) begin
        hit_idx = IDX_W'(i);
        hit_ppn = hit_ppn | mem[i].ppn;
      end
    end
  end

  assign hit       = |match;
  assign multi_hit = !$onehot0(match);

  // Scan downward so the lowest free slot wins.
  always_comb begin
    any_inv = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!mem[i].valid) begin
        any_inv = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_cache_unit.sv
// Small fully-associative translation cache behind the translator TLB port.
// Hits answer locally; misses issue a page walk and install on fill.
module tlb_cache_unit
  import translator_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  tlb_if.slave             tlb_req,
  output logic             walk_valid,
  output pn_t              walk_vpn,
  input  logic             walk_ready,
  input  logic             fill_valid,
  input  pn_t              fill_ppn,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_cache_state_t state_q, state_d;
  pn_t              vpn_q, ppn_q;
  logic [IDX_W-1:0] rr_ptr;

  logic             hit, multi_hit, any_inv;
  logic [IDX_W-1:0] hit_idx, inv_idx;
  pn_t              hit_ppn;
  logic             we, rr_inc;
  logic [IDX_W-1:0] widx;
  tlb_entry_t       wentry;

  tlb_cache_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_vpn (vpn_q),
    .flush      (flush),
    .we         (we),
    .widx       (widx),
    .wentry     (wentry),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .hit_ppn    (hit_ppn),
    .multi_hit  (multi_hit),
    .any_inv    (any_inv),
    .inv_idx    (inv_idx)
  );

  assign wentry = '{valid: 1'b1, vpn: vpn_q, ppn: fill_ppn};

  always_comb begin
    state_d    = state_q;
    we         = 1'b0;
    widx       = rr_ptr;
    rr_inc     = 1'b0;
    unique case (state_q)
      S_IDLE:   if (tlb_req.valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit ? S_RESP : S_WALK;
      S_WALK:   if (walk_ready) state_d = S_FILL;
      S_FILL: begin
        if (fill_valid) begin
          state_d = S_RESP;
          // A flush in the fill cycle drops the install.
          if (!flush) begin
            we = 1'b1;
            if (any_inv) begin
              widx = inv_idx;
            end else begin
              rr_inc = 1'b1;
            end
          end
        end
      end
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      ppn_q    <= '0;
      rr_ptr   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && tlb_req.valid) begin
        vpn_q <= tlb_req.vpn;
      end
      if (state_q == S_LOOKUP) begin
        if (hit) begin
          ppn_q   <= hit_ppn;
          hit_cnt <= hit_cnt + 1'b1;
        end else begin
          miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if (state_q == S_FILL && fill_valid) begin
        ppn_q <= fill_ppn;
      end
      if (rr_inc) begin
        rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  assign tlb_req.ack = (state_q == S_RESP);
  assign tlb_req.ppn = tlb_req.ack ? ppn_q : '0;
  assign walk_valid  = (state_q == S_WALK);
  assign walk_vpn    = walk_valid ? vpn_q : '0;

  a_valid_held: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q inside {S_LOOKUP, S_WALK, S_FILL})
      |-> tlb_req.valid);

  a_one_hot: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_LOOKUP) |-> !multi_hit);

  a_hit_idx: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_LOOKUP && hit)
      |-> (32'(hit_idx) < ENTRIES));

  a_fill_state: assert property (
    @(posedge clk) disable iff (!rst_n)
    fill_valid |-> (state_q == S_FILL));

endmodule
